uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter: CLK_PER_HALF_BIT, default 5208, clock cycles per half UART bit time; 5208 gives 9600 baud at 100 MHz.
REQ-002 SHALL have port: clock  input  1  system clock; all logic on the rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: rxd  input  1  asynchronous UART line; idle high.
REQ-005 SHALL have port: rx_ready  output  1  one-cycle pulse; rdata holds a new valid byte.
REQ-006 SHALL have port: rdata  output  8  last correctly received byte.
REQ-007 SHALL have port: ferr  output  1  one-cycle pulse on framing error (stop bit sampled low).

Function
REQ-008 SHALL pass rxd through a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-009 SHALL use frame format 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
REQ-010 SHALL define bit period CLK_PER_BIT = 2*CLK_PER_HALF_BIT cycles; the bit counter width SHALL hold CLK_PER_BIT-1 without overflow.
REQ-011 SHALL implement the state machine IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-012 IDLE: while rxs=0, SHALL clear the counter and go to START.
REQ-013 START: at count CLK_PER_HALF_BIT-1, SHALL sample rxs at mid start bit: 0 -> DATA with counter and bit index cleared; 1 -> IDLE, treated as a glitch with no output pulse.
REQ-014 DATA: at count CLK_PER_BIT-1, SHALL shift rxs into bit[index] and clear the counter; after index 7 SHALL go to STOP.
REQ-015 STOP: at count CLK_PER_BIT-1, if rxs=1 SHALL load rdata from the shift register, pulse rx_ready on the next cycle, and go to IDLE.
REQ-016 STOP: at count CLK_PER_BIT-1, if rxs=0 SHALL pulse ferr, leave rdata unchanged, not pulse rx_ready, and go to WAIT_HIGH.
REQ-017 WAIT_HIGH: SHALL stay until rxs=1, then go to IDLE; a held-low line (break) SHALL produce exactly one ferr.
REQ-018 rx_ready and ferr SHALL each be high for exactly one cycle per frame and SHALL never be high together.
REQ-019 rdata SHALL change only in the cycle rx_ready rises, and SHALL be stable between pulses.
REQ-020 SHALL accept back-to-back frames: a start edge seen on the first cycle in IDLE after STOP SHALL be received with no lost byte.
REQ-021 Latency: rx_ready SHALL rise 1 cycle after the mid-stop-bit sample, i.e. 2 sync cycles + 9.5 bit times + 1 cycle after the falling edge of the start bit on rxd.
REQ-022 rx_ready SHALL connect directly to the loader's rx_ready/rdata inputs; the block SHALL have no backpressure, and a consumer that misses a pulse loses the byte.

Reset
REQ-023 On reset, state SHALL be IDLE, counter and bit index 0, both synchronizer flops 1, rx_ready=0, ferr=0, rdata=8'h00.
REQ-024 Reset mid-frame SHALL discard the partial byte with no pulse; if rxd is still low after reset, the remaining frame bits SHALL be treated as a new start.

Structure
REQ-025 The state enum typedef and the 8N1 frame constants (DATA_BITS=8) SHALL live in shared package uart_pkg, reused by the UART transmitter.
REQ-026 The synchronizer SHALL be sub-module sync2 (2 flops, reset value parameterized, default 1); no other sub-modules.

Verification
REQ-027 Bench SHALL run at CLK_PER_HALF_BIT=4 (8-cycle bit) unless noted, with reset held for 3 cycles.
REQ-028 Send 0x99 -> exactly one rx_ready, rdata=8'h99, ferr never high.
REQ-029 Send 0x55 then 0xAA back-to-back with no idle gap -> two rx_ready pulses, rdata 8'h55 then 8'hAA, pulses 80 cycles apart.
REQ-030 rxd low for 3 cycles in idle -> no rx_ready, no ferr, state returns to IDLE.
REQ-031 Send 0x3C with stop bit 0, then hold rxd low 40 cycles, then send 0x01 -> one ferr, rdata stays at its previous value, then rx_ready with rdata=8'h01.
REQ-032 Assert reset for 1 cycle during data bit 4 of 0xF0, with rxd high thereafter -> no pulses, outputs at reset values; next frame 0x12 -> rdata=8'h12.
REQ-033 At default parameter, send 0x99 at 9600 baud with +2% bit-rate skew -> rdata=8'h99.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions used by the receiver and the transmitter.
//   uart_state_t : frame state machine encoding
//   DATA_BITS    : data bits per 8N1 frame
//   START_BIT    : line level of the start bit
//   STOP_BIT     : line level of the stop bit
//   IDX_W        : width of a data bit index
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_state_t;

    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   IDX_W     = $clog2(DATA_BITS);

endpackage

// File: rtl/uart_rx_sync2.sv
// sync2: two-flop synchronizer for a single asynchronous bit.
//   clock     : sampling clock
//   reset     : synchronous, active-high; both flops load RESET_VAL
//   d         : asynchronous input
//   q         : synchronized output (two clock cycles of latency)
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [1:0] ff;

    always_ff @(posedge clock) begin
        if (reset) ff <= {2{RESET_VAL}};
        else       ff <= {ff[0], d};
    end

    assign q = ff[1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling.
//   clock    : system clock, rising edge
//   reset    : synchronous, active-high
//   rxd      : asynchronous serial line, idle high
//   rx_ready : one-cycle pulse, rdata holds a freshly received byte
//   rdata    : last correctly framed byte
//   ferr     : one-cycle pulse when the stop bit is sampled low
// There is no backpressure: a consumer that misses rx_ready loses the byte.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 5208
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rxd,
    output logic       rx_ready,
    output logic [7:0] rdata,
    output logic       ferr
);

    localparam int CLK_PER_BIT = 2 * CLK_PER_HALF_BIT;
    localparam int CNT_W       = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic                 rxs;
    uart_state_t          state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shreg;

    sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (rxd),
        .q     (rxs)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            shreg    <= '0;
            rdata    <= 8'h00;
            rx_ready <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            rx_ready <= 1'b0;
            ferr     <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rxs == START_BIT) state <= START;
                end
                START: begin
                    // Half a bit in: a line back high means the edge was a glitch.
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        idx <= '0;
                        state <= (rxs == START_BIT) ? DATA : IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt        <= '0;
                        shreg[idx] <= rxs;
                        if (idx == IDX_LAST) state <= STOP;
                        else                 idx   <= idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rxs == STOP_BIT) begin
                            rdata    <= shreg;
                            rx_ready <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            ferr  <= 1'b1;
                            state <= WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    // A held-low line (break) must not start a new frame.
                    if (rxs == STOP_BIT) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
